// File: rtl/nn_pool_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nn_pool_window: OR-pools P conv-node bitstreams, counts pulses per input  |
// | over a fixed window, then reports the argmax on a valid/ready handshake.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module nn_pool_window #(
  parameter int P      = 4,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 9,
  parameter int IDX_W  = 2
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic [P-1:0]     a_in,
  input  logic             EN,
  input  logic             ready,
  output logic             a_pool,
  output logic             valid,
  output logic [CNT_W-1:0] cnt_out,
  output logic [IDX_W-1:0] idx_out
);

  localparam int               WIN_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] C_WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_COMPARE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [P];
  logic [CNT_W-1:0] w_cnt_inc [P];
  logic [WIN_W-1:0] r_win;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_best;
  logic [IDX_W-1:0] r_best_idx;
  logic [CNT_W-1:0] w_cand;
  logic             w_cmp_last;
  logic [CNT_W-1:0] w_best_nxt;
  logic [IDX_W-1:0] w_best_idx_nxt;

  generate
    for (genvar p = 0; p < P; p++) begin : g_sat
      assign w_cnt_inc[p] = (a_in[p] && (r_cnt[p] != C_CNT_MAX)) ?
                            r_cnt[p] + CNT_W'(1) : r_cnt[p];
    end
  endgenerate

  // With a single input there is nothing to compare; the lone edge just latches.
  generate
    if (P > 1) begin : g_cand_multi
      localparam logic [IDX_W-1:0] C_PTR_LAST = IDX_W'(P - 1);
      assign w_cand     = r_cnt[r_ptr];
      assign w_cmp_last = (r_ptr == C_PTR_LAST);
    end else begin : g_cand_single
      assign w_cand     = '0;
      assign w_cmp_last = 1'b1;
    end
  endgenerate

  // Strictly greater keeps the lowest index on ties.
  always_comb begin
    w_best_nxt     = r_best;
    w_best_idx_nxt = r_best_idx;
    if (w_cand > r_best) begin
      w_best_nxt     = w_cand;
      w_best_idx_nxt = r_ptr;
    end
  end

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_ptr      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      a_pool     <= 1'b0;
      valid      <= 1'b0;
      cnt_out    <= '0;
      idx_out    <= '0;
      for (int p = 0; p < P; p++) r_cnt[p] <= '0;
    end else begin
      a_pool <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (EN) begin
            for (int p = 0; p < P; p++) r_cnt[p] <= '0;
            r_win   <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!EN) begin
            r_state <= S_IDLE;
          end else begin
            a_pool <= |a_in;
            for (int p = 0; p < P; p++) r_cnt[p] <= w_cnt_inc[p];
            r_win <= r_win + WIN_W'(1);
            if (r_win == C_WIN_LAST) begin
              r_best     <= w_cnt_inc[0];
              r_best_idx <= '0;
              r_ptr      <= IDX_W'(1);
              r_state    <= S_COMPARE;
            end
          end
        end
        S_COMPARE: begin
          r_best     <= w_best_nxt;
          r_best_idx <= w_best_idx_nxt;
          r_ptr      <= r_ptr + IDX_W'(1);
          if (w_cmp_last) begin
            cnt_out <= w_best_nxt;
            idx_out <= w_best_idx_nxt;
            valid   <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            if (EN) begin
              for (int p = 0; p < P; p++) r_cnt[p] <= '0;
              r_win   <= '0;
              r_state <= S_ACCUM;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_pool_window.sv
`default_nettype none
// Directed bench for nn_pool_window: a P=4 instance and a P=2 saturating instance,
// expected results queued at window start and checked when valid appears.
module tb_nn_pool_window;

  logic       CLK  = 1'b0;
  logic       INIT = 1'b0;
  logic [3:0] a_in = '0;
  logic       EN   = 1'b0;
  logic       ready = 1'b0;
  logic       a_pool, valid;
  logic [3:0] cnt_out;
  logic [1:0] idx_out;

  logic [1:0] s_a_in  = '0;
  logic       s_en    = 1'b0;
  logic       s_ready = 1'b0;
  logic       s_a_pool, s_valid;
  logic [2:0] s_cnt_out;
  logic [0:0] s_idx_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt[$];
  logic [31:0] exp_idx[$];

  always #5 CLK = ~CLK;

  nn_pool_window #(.P(4), .WINDOW(8), .CNT_W(4), .IDX_W(2)) dut (
    .CLK(CLK), .INIT(INIT), .a_in(a_in), .EN(EN), .ready(ready),
    .a_pool(a_pool), .valid(valid), .cnt_out(cnt_out), .idx_out(idx_out)
  );

  nn_pool_window #(.P(2), .WINDOW(10), .CNT_W(3), .IDX_W(1)) dut_s (
    .CLK(CLK), .INIT(INIT), .a_in(s_a_in), .EN(s_en), .ready(s_ready),
    .a_pool(s_a_pool), .valid(s_valid), .cnt_out(s_cnt_out), .idx_out(s_idx_out)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int c, input int i);
    exp_cnt.push_back(32'(c));
    exp_idx.push_back(32'(i));
  endtask

  // Waits (bounded) for valid, then checks latency and pops the expected result.
  task automatic get_result(input bit sat, input string tag, input int exp_ticks);
    int n = 0;
    logic [31:0] c, i;
    while (((sat ? s_valid : valid) !== 1'b1) && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_ticks));
    c = sat ? 32'(s_cnt_out) : 32'(cnt_out);
    i = sat ? 32'(s_idx_out) : 32'(idx_out);
    chk({tag, "_cnt"}, c, exp_cnt.pop_front());
    chk({tag, "_idx"}, i, exp_idx.pop_front());
  endtask

  initial begin
    // Reset state held through an edge
    tick();
    chk("rst_a_pool", 32'(a_pool), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_cnt", 32'(cnt_out), 0);
    chk("rst_idx", 32'(idx_out), 0);

    // Asynchronous reset mid-ACCUM
    INIT = 1'b1; EN = 1'b1; a_in = 4'b1111;
    tick(); tick(); tick();
    chk("pre_rst_a_pool", 32'(a_pool), 1);
    #2 INIT = 1'b0;
    #1;
    chk("async_a_pool", 32'(a_pool), 0);
    chk("async_valid", 32'(valid), 0);
    chk("async_cnt", 32'(cnt_out), 0);
    chk("async_idx", 32'(idx_out), 0);
    tick();
    INIT = 1'b1; EN = 1'b0; a_in = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_valid", 32'(valid), 0);
      chk("idle_a_pool", 32'(a_pool), 0);
    end

    // Single winner: input 2 fires every sample
    EN = 1'b1; ready = 1'b0; a_in = 4'b0100;
    tick();
    push_exp(8, 2);
    chk("win_a_pool_start", 32'(a_pool), 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("win_a_pool", 32'(a_pool), (k <= 8) ? 32'd1 : 32'd0);
      chk("win_valid_early", 32'(valid), 0);
    end
    get_result(1'b0, "win", 1);

    // Back-pressure: result held while ready is low
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(valid), 1);
      chk("bp_cnt", 32'(cnt_out), 8);
      chk("bp_idx", 32'(idx_out), 2);
    end

    // Handshake with EN high restarts accumulation with cleared counters
    ready = 1'b1; EN = 1'b1; a_in = 4'b0000;
    tick();
    ready = 1'b0;
    chk("restart_valid", 32'(valid), 0);
    chk("restart_cnt_kept", 32'(cnt_out), 8);
    push_exp(8, 0);
    for (int k = 1; k <= 8; k++) begin
      a_in = {1'b1, 1'b0, k[0], 1'b1};
      tick();
    end
    get_result(1'b0, "tie", 3);

    ready = 1'b1; EN = 1'b0;
    tick();
    ready = 1'b0;
    chk("hs_valid", 32'(valid), 0);
    chk("hs_cnt_kept", 32'(cnt_out), 8);
    chk("hs_idx_kept", 32'(idx_out), 0);

    // Abort at the third ACCUM edge
    EN = 1'b1; a_in = 4'b1111;
    tick(); tick(); tick();
    chk("abort_a_pool_pre", 32'(a_pool), 1);
    EN = 1'b0;
    tick();
    chk("abort_a_pool", 32'(a_pool), 0);
    chk("abort_valid", 32'(valid), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("abort_idle_valid", 32'(valid), 0);
    end
    EN = 1'b1; a_in = 4'b0001;
    tick();
    push_exp(8, 0);
    for (int k = 0; k < 8; k++) tick();
    get_result(1'b0, "post_abort", 3);

    // Saturation on the P=2, CNT_W=3 instance
    s_en = 1'b1; s_a_in = 2'b11;
    tick();
    push_exp(7, 0);
    get_result(1'b1, "sat", 11);
    chk("sat_a_pool_off", 32'(s_a_pool), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nn_pool_window.md
# nn_pool_window

Downstream pooling stage for a bank of convolution nodes. It takes the `a_out` burst streams of P neighbouring convolution nodes and forwards their OR as a stochastic max-pooled bitstream to the next layer. Over a fixed measurement window it also counts pulses per input, then runs a sequential argmax. It presents the winning node index and its pulse count on a valid/ready handshake for readout and training logic.

## Interface

**Parameters**
- `P`, default 4: number of pooled convolution-node outputs (≥1).
- `WINDOW`, default 256: measurement window length in clock cycles (≥1).
- `CNT_W`, default 9: pulse-counter width. Counters saturate at 2^CNT_W−1.
- `IDX_W`, default 2: index width, equal to max(1, clog2(P)).

**Ports**
- `CLK` (in, 1): single clock. All state updates on the rising edge.
- `INIT` (in, 1): reset, asynchronous and active-low.
- `a_in` (in, P): convolution-node `a_out` bits, one per node.
- `EN` (in, 1): start/continue measurement.
- `ready` (in, 1): consumer accepts the result.
- `a_pool` (out, 1): registered OR of `a_in`. This is the pooled stochastic stream.
- `valid` (out, 1): result available.
- `cnt_out` (out, CNT_W): pulse count of the winning input.
- `idx_out` (out, IDX_W): index of the winning input.

## Operation

**Reset**
- While `INIT` = 0, and immediately on its assertion:
  - state = IDLE
  - all P counters = 0
  - window counter = 0
  - compare pointer = 0
  - `a_pool` = 0, `valid` = 0, `cnt_out` = 0, `idx_out` = 0
- Reset asserted mid-operation discards all progress.

**States: IDLE, ACCUM, COMPARE, HOLD**
- **IDLE**
  - `EN` = 1 at an edge → ACCUM.
  - On that same edge: clear all counters and the window counter.
- **ACCUM**
  - Each edge: `count[p]` += `a_in[p]`, saturating at 2^CNT_W−1 with no wrap.
  - Window counter increments.
  - After exactly WINDOW sampling edges → COMPARE.
  - On that transition edge: best = `count[0]`, best index = 0, pointer = 1.
  - `EN` = 0 sampled at any ACCUM edge → IDLE. No result is produced and that edge's `a_in` is not counted.
- **COMPARE**
  - One candidate per edge: if `count[ptr]` > best, then best = `count[ptr]` and best index = ptr.
  - Comparison is strictly greater, so the lowest index wins ties.
  - Takes P−1 edges; with P = 1 it takes one edge.
  - Then → HOLD, with `cnt_out` = best, `idx_out` = best index, `valid` = 1.
  - `EN` is ignored in COMPARE.
- **HOLD**
  - `valid` = 1. `cnt_out` and `idx_out` stay stable until the handshake.
  - `valid` & `ready` at an edge: `valid` = 0 from the next cycle.
    - If `EN` = 1 on that edge → ACCUM, with counters cleared.
    - Otherwise → IDLE.
  - `cnt_out` and `idx_out` keep their last value after the handshake.

**a_pool**
- `a_pool` ← |`a_in` on every edge while the state is ACCUM.
- `a_pool` ← 0 in all other states.

## Timing

- Let `EN` be sampled high in IDLE at edge k.
- Counted samples are `a_in` at edges k+1 … k+WINDOW.
- The COMPARE edges follow those sampling edges.
- `valid` rises after edge k+WINDOW+max(P−1,1). For P=4 that is edge k+WINDOW+3.
- `a_pool` has one cycle of latency from `a_in`. It is active for the outputs of edges k+1 … k+WINDOW.
- Minimum period between results with `ready` tied high and `EN` held: WINDOW+max(P−1,1)+1 cycles.
- `valid` never rises while the state is IDLE, ACCUM or COMPARE.
- Data is never lost under back-pressure: HOLD lasts indefinitely.

## Test plan

1. **Reset.** Drive `INIT`=0 asynchronously mid-ACCUM with `a_in`=4'b1111. All outputs read 0 with no clock edge. After release with `EN`=0, state stays IDLE and `valid`=0.
2. **Single winner.** P=4, WINDOW=8, CNT_W=4. Hold `EN`=1, `ready`=0, `a_in`=4'b0100 for all 8 ACCUM edges. `valid` rises 11 edges after the start edge, with `cnt_out`=8, `idx_out`=2. `a_pool`=1 for 8 consecutive cycles, then 0.
3. **Tie and counting.** Same parameters. `a_in[0]` and `a_in[3]` = 1 on every edge. `a_in[1]` = 1 on alternate edges. `a_in[2]` = 0. Result: `cnt_out`=8, `idx_out`=0.
4. **Saturation.** P=2, WINDOW=10, CNT_W=3, `a_in`=2'b11 throughout. Result: `cnt_out`=7, `idx_out`=0, with no wrap to 2.
5. **Back-pressure and restart.** After scenario 2, hold `ready`=0 for 5 cycles: `valid`, `cnt_out` and `idx_out` stay stable. Pulse `ready`=1 for one edge with `EN`=1: `valid`=0 next cycle and a new ACCUM begins with counters zeroed.
6. **Abort.** Drop `EN` at the 3rd ACCUM edge: the block returns to IDLE, `valid` stays 0 and `a_pool`=0 next cycle. A subsequent full window of `a_in`=4'b0001 yields `cnt_out`=8, `idx_out`=0, with no residue from the aborted run.
